clock_switch_ctrl: RTL and testbench

Sequencer for the crypto-clock source mux and the 20-pin clock output enable. Decodes clock-select register and DIP switches into a requested source and output enable, and switches the mux only after the output is gated off and a drain interval has elapsed, so the target never sees a runt pulse. Watches the external clock through a synchronized activity tick and flags loss. Runs entirely on `usb_clk`; its `O_cclk_sel` drives the crypto-clock mux select and `O_cclk_out_en` drives the clock-output DDR enable.

---
 rtl/clk_ctrl_pkg.sv | 51 +++++
 rtl/clk_loss_watchdog.sv | 59 +++++
 rtl/clock_switch_ctrl.sv | 151 +++++++++++++++
 tb/tb_clock_switch_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clk_ctrl_pkg
// Shared types, constants and request-decode helpers for clock_switch_ctrl.
//   state_t      : sequencer states (STABLE, DRAIN, SETTLE)
//   SRC_*        : clock-register source field encodings
//   OUT_*        : clock-register output field encodings
//   decode_src() : requested mux source (0 = PLL1, 1 = external)
//   decode_en()  : requested clock-output enable
// -----------------------------------------------------------------------------
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        STABLE = 2'd0,
        DRAIN  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam logic [2:0] SRC_PLL = 3'b001;
    localparam logic [2:0] SRC_EXT = 3'b101;
    localparam logic [1:0] OUT_OFF = 2'b00;
    localparam logic [1:0] OUT_ON  = 2'b01;
    localparam int         CNT_W   = 8;

    // An explicit source code in the register wins; otherwise the DIP decides,
    // unless the register override flag is set.
    function automatic logic decode_src(input logic [4:0] clock_reg, input logic j16);
        logic src;
        if (clock_reg[2:0] == SRC_PLL) begin
            src = 1'b0;
        end else if (clock_reg[2:0] == SRC_EXT) begin
            src = 1'b1;
        end else if ((clock_reg[0] == 1'b0) && (j16 == 1'b1)) begin
            src = 1'b1;
        end else begin
            src = 1'b0;
        end
        return src;
    endfunction

    // With the override flag set the output field rules; otherwise the DIP does.
    function automatic logic decode_en(input logic [4:0] clock_reg, input logic k16);
        logic en;
        if (clock_reg[0] == 1'b1) begin
            en = (clock_reg[4:3] == OUT_ON);
        end else begin
            en = k16;
        end
        return en;
    endfunction

endpackage

// File: rtl/clk_loss_watchdog.sv
// -----------------------------------------------------------------------------
// clk_loss_watchdog
// Counts usb_clk cycles since the last external-clock activity tick and flags
// loss once the count reaches LOSS_TIMEOUT (count saturates there).
// Ports:
//   usb_clk   in  : clock
//   I_reset_n in  : asynchronous active-low reset (counter = timeout, lost = 1)
//   I_tick    in  : single-cycle activity pulse, usb_clk domain
//   O_lost    out : registered loss flag
// -----------------------------------------------------------------------------
module clk_loss_watchdog
    import clk_ctrl_pkg::*;
#(
    parameter int LOSS_TIMEOUT = 255
) (
    input  logic usb_clk,
    input  logic I_reset_n,
    input  logic I_tick,
    output logic O_lost
);

    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(LOSS_TIMEOUT);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_lost;

    // Next watchdog count: clear on tick, otherwise saturating increment.
    always_comb begin
        w_cnt_next = r_cnt;
        if (I_tick) begin
            w_cnt_next = {CNT_W{1'b0}};
        end else if (r_cnt == TIMEOUT) begin
            w_cnt_next = TIMEOUT;
        end else begin
            w_cnt_next = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter and loss flag; flag rises together with the count hitting timeout.
    always_ff @(posedge usb_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            r_cnt  <= TIMEOUT;
            r_lost <= 1'b1;
        end else begin
            r_cnt <= w_cnt_next;
            if (I_tick) begin
                r_lost <= 1'b0;
            end else if (w_cnt_next == TIMEOUT) begin
                r_lost <= 1'b1;
            end else begin
                r_lost <= r_lost;
            end
        end
    end

    assign O_lost = r_lost;

endmodule

// File: rtl/clock_switch_ctrl.sv
// -----------------------------------------------------------------------------
// clock_switch_ctrl
// Glitch-free sequencer for the crypto-clock source mux and clock-output enable.
// The output is gated for DRAIN_CYCLES before the mux select moves and stays
// gated SETTLE_CYCLES afterwards. Optional feature macro CLK_AUTO_FALLBACK_EN:
// forces the PLL source while the external clock is flagged lost.
// Ports:
//   usb_clk, I_reset_n       : clock, async active-low reset
//   I_clock_reg[4:0]         : [2:0] source, [0] override flag, [4:3] output
//   I_j16_sel, I_k16_sel     : asynchronous DIP inputs (ext source / output on)
//   I_ext_clk_tick           : external-clock activity pulse
//   O_cclk_sel               : mux select, 0 = PLL1, 1 = external
//   O_cclk_out_en            : clock-output enable
//   O_busy                   : switch sequence in progress
//   O_ext_lost               : external clock lost
//   O_switch_count[7:0]      : completed select changes (wraps)
// -----------------------------------------------------------------------------
module clock_switch_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int LOSS_TIMEOUT  = 255
) (
    input  logic       usb_clk,
    input  logic       I_reset_n,
    input  logic [4:0] I_clock_reg,
    input  logic       I_j16_sel,
    input  logic       I_k16_sel,
    input  logic       I_ext_clk_tick,
    output logic       O_cclk_sel,
    output logic       O_cclk_out_en,
    output logic       O_busy,
    output logic       O_ext_lost,
    output logic [7:0] O_switch_count
);

    localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    logic             r_j16_meta, r_j16_sync;
    logic             r_k16_meta, r_k16_sync;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_target;
    logic             r_sel;
    logic             r_out_en;
    logic             r_busy;
    logic [7:0]       r_switch_count;
    logic             w_ext_lost;
    logic             w_req_src;
    logic             w_req_en;
    logic             w_eff_src;

    clk_loss_watchdog #(
        .LOSS_TIMEOUT (LOSS_TIMEOUT)
    ) u_watchdog (
        .usb_clk   (usb_clk),
        .I_reset_n (I_reset_n),
        .I_tick    (I_ext_clk_tick),
        .O_lost    (w_ext_lost)
    );

    // Two-flop synchronizers for the asynchronous DIP switches.
    always_ff @(posedge usb_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            r_j16_meta <= 1'b0;
            r_j16_sync <= 1'b0;
            r_k16_meta <= 1'b0;
            r_k16_sync <= 1'b0;
        end else begin
            r_j16_meta <= I_j16_sel;
            r_j16_sync <= r_j16_meta;
            r_k16_meta <= I_k16_sel;
            r_k16_sync <= r_k16_meta;
        end
    end

    assign w_req_src = decode_src(I_clock_reg, r_j16_sync);
    assign w_req_en  = decode_en(I_clock_reg, r_k16_sync);

`ifdef CLK_AUTO_FALLBACK_EN
    assign w_eff_src = w_req_src & ~w_ext_lost;
`else
    assign w_eff_src = w_req_src;
`endif

    // Switch sequencer: gate output, drain, move select, settle, re-enable.
    always_ff @(posedge usb_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            r_state        <= STABLE;
            r_cnt          <= {CNT_W{1'b0}};
            r_target       <= 1'b0;
            r_sel          <= 1'b0;
            r_out_en       <= 1'b0;
            r_busy         <= 1'b0;
            r_switch_count <= 8'd0;
        end else begin
            case (r_state)
                STABLE: begin
                    if (w_eff_src != r_sel) begin
                        r_target <= w_eff_src;
                        r_out_en <= 1'b0;
                        r_busy   <= 1'b1;
                        r_cnt    <= DRAIN_LOAD;
                        r_state  <= DRAIN;
                    end else begin
                        r_out_en <= w_req_en;
                    end
                end
                DRAIN: begin
                    if (r_cnt == {CNT_W{1'b0}}) begin
                        r_sel          <= r_target;
                        r_switch_count <= r_switch_count + 8'd1;
                        r_cnt          <= SETTLE_LOAD;
                        r_state        <= SETTLE;
                    end else begin
                        r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                SETTLE: begin
                    if (r_cnt != {CNT_W{1'b0}}) begin
                        r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                    end else if (w_eff_src == r_sel) begin
                        r_busy   <= 1'b0;
                        r_out_en <= w_req_en;
                        r_state  <= STABLE;
                    end else begin
                        // Request moved during the sequence: go again, output stays gated.
                        r_target <= w_eff_src;
                        r_cnt    <= DRAIN_LOAD;
                        r_state  <= DRAIN;
                    end
                end
                default: begin
                    r_out_en <= 1'b0;
                    r_busy   <= 1'b0;
                    r_cnt    <= {CNT_W{1'b0}};
                    r_state  <= STABLE;
                end
            endcase
        end
    end

    assign O_cclk_sel     = r_sel;
    assign O_cclk_out_en  = r_out_en;
    assign O_busy         = r_busy;
    assign O_ext_lost     = w_ext_lost;
    assign O_switch_count = r_switch_count;

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_switch_ctrl
// Directed bench for clock_switch_ctrl with default parameters
// (DRAIN 4, SETTLE 16, LOSS_TIMEOUT 255). Expected values are hand-derived
// cycle counts relative to the edge at which a new request is first sampled.
// -----------------------------------------------------------------------------
module tb_clock_switch_ctrl;

    logic       usb_clk;
    logic       I_reset_n;
    logic [4:0] I_clock_reg;
    logic       I_j16_sel;
    logic       I_k16_sel;
    logic       I_ext_clk_tick;
    logic       O_cclk_sel;
    logic       O_cclk_out_en;
    logic       O_busy;
    logic       O_ext_lost;
    logic [7:0] O_switch_count;

    int  n_vec;
    int  n_err;
    logic tick_en;
    int  tk;
    logic fb;

    clock_switch_ctrl u_dut (
        .usb_clk        (usb_clk),
        .I_reset_n      (I_reset_n),
        .I_clock_reg    (I_clock_reg),
        .I_j16_sel      (I_j16_sel),
        .I_k16_sel      (I_k16_sel),
        .I_ext_clk_tick (I_ext_clk_tick),
        .O_cclk_sel     (O_cclk_sel),
        .O_cclk_out_en  (O_cclk_out_en),
        .O_busy         (O_busy),
        .O_ext_lost     (O_ext_lost),
        .O_switch_count (O_switch_count)
    );

    // 100 MHz usb_clk.
    initial begin
        usb_clk = 1'b0;
        forever #5 usb_clk = ~usb_clk;
    end

    // External activity ticks, one every 10 cycles while enabled.
    initial begin
        I_ext_clk_tick = 1'b0;
        tk = 0;
        forever begin
            @(posedge usb_clk);
            #1;
            if (tick_en && tk == 9) begin
                I_ext_clk_tick = 1'b1;
                tk = 0;
            end else begin
                I_ext_clk_tick = 1'b0;
                if (tick_en) tk = tk + 1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge usb_clk);
            #1;
        end
    endtask

    initial begin
        int n_lost;
        n_vec = 0;
        n_err = 0;
`ifdef CLK_AUTO_FALLBACK_EN
        fb = 1'b1;
`else
        fb = 1'b0;
`endif
        tick_en     = 1'b0;
        I_reset_n   = 1'b0;
        I_clock_reg = 5'b00000;
        I_j16_sel   = 1'b0;
        I_k16_sel   = 1'b0;
        step(3);
        check_val("rst_sel",   32'(O_cclk_sel),     32'd0);
        check_val("rst_en",    32'(O_cclk_out_en),  32'd0);
        check_val("rst_busy",  32'(O_busy),         32'd0);
        check_val("rst_count", 32'(O_switch_count), 32'd0);
        check_val("rst_lost",  32'(O_ext_lost),     32'd1);

        I_reset_n = 1'b1;
        tick_en   = 1'b1;
        step(12);
        check_val("tick_clears_lost", 32'(O_ext_lost), 32'd0);

        // Enable-only changes: one cycle, no sequence.
        I_clock_reg = 5'b01001;
        step(1);
        check_val("en_on",       32'(O_cclk_out_en), 32'd1);
        check_val("en_on_busy",  32'(O_busy),        32'd0);
        check_val("en_on_sel",   32'(O_cclk_sel),    32'd0);
        I_clock_reg = 5'b00001;
        step(1);
        check_val("en_off",      32'(O_cclk_out_en), 32'd0);
        check_val("en_off_busy", 32'(O_busy),        32'd0);
        I_clock_reg = 5'b01001;
        step(1);
        check_val("en_on2",      32'(O_cclk_out_en), 32'd1);

        // PLL -> ext: gate at 1, sel at 5, re-enable at 21.
        I_clock_reg = 5'b01101;
        for (int i = 1; i <= 21; i++) begin
            step(1);
            check_val($sformatf("sw1_sel_%0d", i),  32'(O_cclk_sel),     (i >= 5) ? 32'd1 : 32'd0);
            check_val($sformatf("sw1_en_%0d", i),   32'(O_cclk_out_en),  (i == 21) ? 32'd1 : 32'd0);
            check_val($sformatf("sw1_busy_%0d", i), 32'(O_busy),         (i < 21) ? 32'd1 : 32'd0);
            check_val($sformatf("sw1_cnt_%0d", i),  32'(O_switch_count), (i >= 5) ? 32'd1 : 32'd0);
        end

        // ext -> PLL, request flips back to ext during DRAIN: two sequences.
        I_clock_reg = 5'b01001;
        for (int i = 1; i <= 41; i++) begin
            step(1);
            if (i == 2) I_clock_reg = 5'b01101;
            check_val($sformatf("sw2_sel_%0d", i),  32'(O_cclk_sel),    (i >= 5 && i < 25) ? 32'd0 : 32'd1);
            check_val($sformatf("sw2_en_%0d", i),   32'(O_cclk_out_en), (i == 41) ? 32'd1 : 32'd0);
            check_val($sformatf("sw2_busy_%0d", i), 32'(O_busy),        (i < 41) ? 32'd1 : 32'd0);
            check_val($sformatf("sw2_cnt_%0d", i),  32'(O_switch_count),
                      32'd1 + ((i >= 5) ? 32'd1 : 32'd0) + ((i >= 25) ? 32'd1 : 32'd0));
        end

        // Hand control to the DIPs (both off): back to PLL.
        I_clock_reg = 5'b00000;
        step(25);
        check_val("dip_pll_sel",   32'(O_cclk_sel),     32'd0);
        check_val("dip_pll_busy",  32'(O_busy),         32'd0);
        check_val("dip_pll_count", 32'(O_switch_count), 32'd4);

        // j16 0->1: sequence starts 3 cycles later.
        I_j16_sel = 1'b1;
        step(2);
        check_val("j16_busy_2", 32'(O_busy), 32'd0);
        step(1);
        check_val("j16_busy_3", 32'(O_busy), 32'd1);
        step(19);
        check_val("j16_busy_22", 32'(O_busy), 32'd1);
        step(1);
        check_val("j16_busy_23", 32'(O_busy),         32'd0);
        check_val("j16_sel",     32'(O_cclk_sel),     32'd1);
        check_val("j16_count",   32'(O_switch_count), 32'd5);
        check_val("j16_en",      32'(O_cclk_out_en),  32'd0);

        // Stop ticks: loss after ~255 tick-free cycles.
        tick_en = 1'b0;
        n_lost  = 0;
        while (O_ext_lost == 1'b0 && n_lost < 400) begin
            step(1);
            n_lost = n_lost + 1;
        end
        check_val("lost_latency_ok", 32'((n_lost >= 240) && (n_lost <= 260)), 32'd1);
        step(25);
        check_val("lost_sel", 32'(O_cclk_sel), fb ? 32'd0 : 32'd1);
        tick_en = 1'b1;
        step(12);
        check_val("recover_lost", 32'(O_ext_lost), 32'd0);
        step(25);
        check_val("recover_sel",   32'(O_cclk_sel),     32'd1);
        check_val("recover_busy",  32'(O_busy),         32'd0);
        check_val("recover_count", 32'(O_switch_count), fb ? 32'd7 : 32'd5);

        // Reset during SETTLE of an ext -> PLL sequence.
        I_clock_reg = 5'b00001;
        step(8);
        check_val("pre_rst_busy", 32'(O_busy), 32'd1);
        #2;
        I_reset_n = 1'b0;
        #1;
        check_val("mid_rst_sel",   32'(O_cclk_sel),     32'd0);
        check_val("mid_rst_en",    32'(O_cclk_out_en),  32'd0);
        check_val("mid_rst_busy",  32'(O_busy),         32'd0);
        check_val("mid_rst_count", 32'(O_switch_count), 32'd0);
        check_val("mid_rst_lost",  32'(O_ext_lost),     32'd1);
        I_clock_reg = 5'b01101;
        step(2);
        I_reset_n = 1'b1;
        step(60);
        check_val("rerun_sel",   32'(O_cclk_sel),     32'd1);
        check_val("rerun_en",    32'(O_cclk_out_en),  32'd1);
        check_val("rerun_busy",  32'(O_busy),         32'd0);
        check_val("rerun_count", 32'(O_switch_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
